sweep_check_ctrl: RTL
=====================

Name: sweep_check_ctrl

Overview:
- Sequencer that drives an N-bit input vector exhaustively (0 to 2^WIDTH-1) into a combinational unit-under-test and its reference model in parallel.
- After a settle window per vector, compares the two 1-bit outputs and accumulates a mismatch count plus the first failing vector.
- Replaces the free-running delay-based stimulus and monitor printing with a clocked, self-checking controller.
- Sits between the bench/top level and the source/reference model pair.

Parameters:
- WIDTH, 3, width of the swept input vector x.
- SETTLE_CYC, 2, cycles x is held stable before outputs are sampled (0 allowed).

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin a sweep; accepted only in IDLE or DONE
- abort  input  1  synchronous abort of a running sweep
- x  output  WIDTH  stimulus vector to unit-under-test and reference
- dut_y  input  1  unit-under-test output
- ref_y  input  1  reference model output
- busy  output  1  sweep in progress
- done  output  1  sweep completed; held until next start
- pass  output  1  done && mismatch_count==0
- mismatch_pulse  output  1  one-cycle pulse on a failing compare edge
- mismatch_count  output  WIDTH+1  number of failing vectors (max 2^WIDTH, no wrap)
- first_fail_valid  output  1  first_fail_vec holds a captured value
- first_fail_vec  output  WIDTH  x value of the first mismatch in this sweep

Behaviour:
- Reset (async, rst_n=0): state IDLE; x=0; busy=0; done=0; pass=0; mismatch_pulse=0; mismatch_count=0; first_fail_valid=0; first_fail_vec=0.
- States: IDLE, SETTLE, COMPARE, DONE.
- IDLE/DONE + start at edge E0:
  - x<=0, settle counter<=SETTLE_CYC.
  - mismatch_count, first_fail_valid, first_fail_vec and done cleared.
  - busy<=1; state<=SETTLE, or COMPARE if SETTLE_CYC=0.
- SETTLE: counter decrements each edge; at 1 go to COMPARE. x is stable throughout.
- COMPARE (one cycle): at the edge, sample dut_y and ref_y.
  - If they differ: mismatch_count+1, mismatch_pulse=1 for the following cycle.
  - On the first mismatch only: capture first_fail_vec=x and set first_fail_valid.
  - If x==2^WIDTH-1: state<=DONE, busy<=0, done<=1.
  - Otherwise: x<=x+1, reload counter, go to SETTLE (or stay in COMPARE if SETTLE_CYC=0).
- Latency: each vector takes SETTLE_CYC+1 cycles. With defaults, done rises 24 cycles after E0 (visible in cycle E0+24).
- DONE: outputs and results held; x holds 2^WIDTH-1. start restarts the sweep (same as from IDLE).
- abort (while busy): next edge -> IDLE, busy=0, done=0.
  - Counters and first_fail fields are retained for debug; x is held.
  - abort has priority over a same-edge COMPARE update: no count or capture on that edge.
- start while busy: ignored. start and abort together in IDLE/DONE: start wins.
- Reset mid-sweep: immediate return to reset values, regardless of state.
- mismatch_count cannot overflow; its width covers 2^WIDTH.

Decomposition:
- Package sweep_pkg holds:
  - state enum (IDLE, SETTLE, COMPARE, DONE);
  - default WIDTH/SETTLE_CYC constants;
  - a function computing the counter width for SETTLE_CYC.
- One natural sub-module: sweep_settle_timer (loadable down-counter with terminal flag), instantiated once.
- FSM, vector register and result registers remain in the top.

Test Plan:
- Defaults, ref_y tied equal to dut_y, pulse start -> x steps 0..7, 3 cycles each; done=1 at cycle E0+24; pass=1; mismatch_count=0; first_fail_valid=0.
- ref model deviates only at x=3'b101 -> mismatch_count=1; first_fail_vec=3'b101; single mismatch_pulse in the cycle after x=5's compare edge; pass=0.
- ref_y = ~dut_y always -> mismatch_count=8 (4'b1000, no wrap); first_fail_vec=0; 8 pulses.
- start re-pulsed at cycle E0+5, then abort at cycle E0+10 -> second start ignored; busy=0 and done=0 next cycle; retained count matches vectors compared so far; new start clears results and completes normally.
- rst_n dropped asynchronously mid-SETTLE with x=4 -> all outputs 0 immediately, without waiting for a clock edge.
- SETTLE_CYC=0 build -> done 8 cycles after start; one compare per cycle; results identical to the default build for the same models.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared types and constants for the exhaustive sweep checker.
// The counter-width helper sizes the settle timer from its reload value.
package sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COMPARE,
        ST_DONE
    } sweep_state_e;

    localparam int DEF_WIDTH      = 3;
    localparam int DEF_SETTLE_CYC = 2;

    // Bits needed to hold settle_cyc; never narrower than one bit.
    function automatic int settle_cnt_width(input int settle_cyc);
        return (settle_cyc < 2) ? 1 : $clog2(settle_cyc + 1);
    endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter that flags the last settle cycle of a vector.
// terminal_o is high while the count is 1, so the FSM leaves SETTLE on that edge.
module sweep_settle_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             terminal_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_d      = cnt_q - 1'b1;
    assign terminal_o = (cnt_q == CNT_W'(1));

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sweep_check_ctrl.sv
// Clocked sequencer that sweeps x over every value, compares the UUT output
// against the reference after a settle window, and records mismatch results.
module sweep_check_ctrl
    import sweep_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] x,
    input  logic             dut_y,
    input  logic             ref_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch_pulse,
    output logic [WIDTH:0]   mismatch_count,
    output logic             first_fail_valid,
    output logic [WIDTH-1:0] first_fail_vec
);

    localparam int               CNT_W  = settle_cnt_width(SETTLE_CYC);
    localparam logic [WIDTH-1:0] X_LAST = '1;

    sweep_state_e     state_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] x_d;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             pulse_q;
    logic [WIDTH:0]   count_q;
    logic [WIDTH:0]   count_d;
    logic             ffv_q;
    logic [WIDTH-1:0] ffvec_q;

    logic start_ok;
    logic mismatch;
    logic timer_load;
    logic timer_dec;
    logic timer_term;

    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign mismatch = dut_y ^ ref_y;
    assign x_d      = x_q + 1'b1;
    assign count_d  = count_q + 1'b1;

    assign timer_load = start_ok ||
                        ((state_q == ST_COMPARE) && !abort && (x_q != X_LAST));
    assign timer_dec  = (state_q == ST_SETTLE);

    sweep_settle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (timer_load),
        .load_val_i (CNT_W'(SETTLE_CYC)),
        .dec_i      (timer_dec),
        .terminal_o (timer_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            pulse_q <= 1'b0;
            count_q <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
        end else begin
            pulse_q <= 1'b0;
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        x_q     <= '0;
                        count_q <= '0;
                        ffv_q   <= 1'b0;
                        ffvec_q <= '0;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= (SETTLE_CYC == 0) ? ST_COMPARE : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else if (timer_term) begin
                        state_q <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    // Abort wins over the compare: results stay as they were.
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else begin
                        if (mismatch) begin
                            count_q <= count_d;
                            pulse_q <= 1'b1;
                            if (!ffv_q) begin
                                ffv_q   <= 1'b1;
                                ffvec_q <= x_q;
                            end
                        end
                        if (x_q == X_LAST) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= !mismatch && (count_q == '0);
                        end else begin
                            x_q     <= x_d;
                            state_q <= (SETTLE_CYC == 0) ? ST_COMPARE : ST_SETTLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign x                = x_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign mismatch_pulse   = pulse_q;
    assign mismatch_count   = count_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;

endmodule
